seq_mul_div: RTL and testbench



---
 rtl/arith_pkg.sv | 13 +
 rtl/seq_mul_div_if.sv | 24 ++
 rtl/addsub_n.sv | 29 ++
 rtl/full_adder.sv | 11 +
 rtl/seq_mul_div.sv | 131 +++++++++++++
 tb/tb_seq_mul_div.sv | 345 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/arith_pkg.sv
// Shared encodings for the arithmetic slow-path units.
package arith_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mul_div_if.sv
// Request/response bundle for the sequential multiply/divide unit.
interface seq_mul_div_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result_hi;
  logic [N-1:0] result_lo;
  logic         div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/addsub_n.sv
// N-bit ripple add/subtract; cout is carry when adding and borrow when subtracting.
module addsub_n #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0]   c;
  logic [N-1:0] y_inv;

  assign y_inv = y ^ {N{sub}};
  assign c[0]  = sub;

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a    (x[i]),
      .b    (y_inv[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  // Two's-complement subtract leaves carry high when no borrow occurred.
  assign cout = c[N] ^ sub;
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/seq_mul_div.sv
// Multi-cycle unsigned shift-add multiplier / restoring divider, one bit per clock.
module seq_mul_div
  import arith_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic          clk,
  input logic          reset,
  seq_mul_div_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  acc_hi_q, acc_hi_d;
  logic [N-1:0]  acc_lo_q, acc_lo_d;
  logic [N-1:0]  res_hi_q, res_hi_d;
  logic [N-1:0]  res_lo_q, res_lo_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  t, add_x, sum, step_hi, step_lo;
  logic [N:0]    mul_hi;
  logic          cout, take;

  assign t     = {acc_hi_q[N-2:0], acc_lo_q[N-1]};
  assign add_x = (op_q == OP_DIV) ? t : acc_hi_q;

  addsub_n #(.N(N)) u_addsub (
    .x    (add_x),
    .y    (b_q),
    .sub  (op_q == OP_DIV),
    .sum  (sum),
    .cout (cout)
  );

  // One iteration of the selected algorithm.
  always_comb begin
    step_hi = acc_hi_q;
    step_lo = acc_lo_q;
    mul_hi  = '0;
    take    = 1'b0;
    if (op_q == OP_MUL) begin
      mul_hi  = acc_lo_q[0] ? {cout, sum} : {1'b0, acc_hi_q};
      step_hi = mul_hi[N:1];
      step_lo = {mul_hi[0], acc_lo_q[N-1:1]};
    end else begin
      // A set top bit means the shifted remainder already exceeds any N-bit divisor.
      take    = acc_hi_q[N-1] | ~cout;
      step_hi = take ? sum : t;
      step_lo = {acc_lo_q[N-2:0], take};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_d     = bus.op;
          b_d      = bus.b;
          acc_hi_d = '0;
          acc_lo_d = bus.a;
          cnt_d    = '0;
          dbz_d    = 1'b0;
          if (bus.op == OP_DIV && bus.b == '0) begin
            state_d  = ST_DONE;
            res_hi_d = bus.a;
            res_lo_d = '1;
            dbz_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        if (cnt_q == CW'(N - 1)) begin
          state_d  = ST_DONE;
          res_hi_d = step_hi;
          res_lo_d = step_lo;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == ST_RUN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.result_hi   = res_hi_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_mul_div.sv
// Scoreboard bench for seq_mul_div at N = 8 and N = 16.
module tb_seq_mul_div;
  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_mul_div_if #(.N(8))  bus8 ();
  seq_mul_div_if #(.N(16)) bus16 ();

  seq_mul_div #(.N(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  seq_mul_div #(.N(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb8[$];
  exp_t sb16[$];

  function automatic exp_t model(input int n, input logic op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t        e;
    logic [31:0] p;
    logic [15:0] mask;
    mask = (n == 16) ? 16'hFFFF : 16'h00FF;
    e    = '0;
    if (op == 1'b0) begin
      p    = {16'h0, a} * {16'h0, b};
      e.lo = p[15:0] & mask;
      e.hi = (n == 16) ? p[31:16] : {8'h0, p[15:8]};
    end else if (b == 16'h0) begin
      e.lo  = mask;
      e.hi  = a;
      e.dbz = 1'b1;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue8(input logic op, input logic [7:0] a, input logic [7:0] b);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    sb8.push_back(model(8, op, {8'h0, a}, {8'h0, b}));
    @(negedge clk);
    bus8.start = 1'b0;
  endtask

  task automatic issue16(input logic op, input logic [15:0] a, input logic [15:0] b);
    bus16.start = 1'b1;
    bus16.op    = op;
    bus16.a     = a;
    bus16.b     = b;
    sb16.push_back(model(16, op, a, b));
    @(negedge clk);
    bus16.start = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    lat = 1;
    while (bus8.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_done16(output int lat);
    lat = 1;
    while (bus16.done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus8.start  = 1'b0;
    bus8.op     = 1'b0;
    bus8.a      = '0;
    bus8.b      = '0;
    bus16.start = 1'b0;
    bus16.op    = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({bus8.busy, bus8.done, bus8.div_by_zero} !== 3'b000) begin
      fails++;
      $display("FAIL reset8_ctrl: got %b expected 000",
               {bus8.busy, bus8.done, bus8.div_by_zero});
    end
    tests++;
    if ({bus8.result_hi, bus8.result_lo} !== 16'h0) begin
      fails++;
      $display("FAIL reset8_result: got %h expected 0000", {bus8.result_hi, bus8.result_lo});
    end
    tests++;
    if ({bus16.busy, bus16.done, bus16.div_by_zero, bus16.result_hi, bus16.result_lo} !== '0)
    begin
      fails++;
      $display("FAIL reset16: got busy=%b done=%b hi=%h lo=%h expected zeros",
               bus16.busy, bus16.done, bus16.result_hi, bus16.result_lo);
    end
  endtask

  task automatic check8(input string name, input int lat, input int exp_lat);
    exp_t e;
    tests++;
    if (lat !== exp_lat) begin
      fails++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    if (sb8.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else begin
      e = sb8.pop_front();
      tests++;
      if ({8'h0, bus8.result_hi} !== e.hi || {8'h0, bus8.result_lo} !== e.lo ||
          bus8.div_by_zero !== e.dbz) begin
        fails++;
        $display("FAIL %s_result: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b", name,
                 bus8.result_hi, bus8.result_lo, bus8.div_by_zero, e.hi[7:0], e.lo[7:0], e.dbz);
      end
    end
  endtask

  task automatic test_mul();
    int lat;
    int bad;
    @(negedge clk);
    issue8(1'b0, 8'd13, 8'd11);
    bad = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) bad++;
      if (c < 8) @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mul_busy_window: got %0d bad cycles expected 0", bad);
    end
    @(negedge clk);
    lat = 9;
    if (bus8.done !== 1'b1) wait_done8(lat);
    check8("mul_13x11", lat, 9);
    tests++;
    if (bus8.busy !== 1'b0) begin
      fails++;
      $display("FAIL mul_busy_at_done: got %b expected 0", bus8.busy);
    end
    @(negedge clk);
    tests++;
    if (bus8.done !== 1'b0 || bus8.result_lo !== 8'h8F || bus8.result_hi !== 8'h00) begin
      fails++;
      $display("FAIL mul_hold: got done=%b hi=%h lo=%h expected done=0 hi=00 lo=8f",
               bus8.done, bus8.result_hi, bus8.result_lo);
    end
    issue8(1'b0, 8'hFF, 8'hFF);
    wait_done8(lat);
    check8("mul_ffxff", lat, 9);
  endtask

  task automatic test_div();
    int lat;
    @(negedge clk);
    issue8(1'b1, 8'd200, 8'd7);
    wait_done8(lat);
    check8("div_200_7", lat, 9);
    @(negedge clk);
    issue8(1'b1, 8'h80, 8'hFF);
    wait_done8(lat);
    check8("div_80_ff", lat, 9);
  endtask

  task automatic test_div_by_zero();
    int lat;
    @(negedge clk);
    issue8(1'b1, 8'h5A, 8'h00);
    tests++;
    if (bus8.busy !== 1'b0) begin
      fails++;
      $display("FAIL dbz_busy: got %b expected 0", bus8.busy);
    end
    wait_done8(lat);
    check8("div_by_zero", lat, 1);
    @(negedge clk);
    tests++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.div_by_zero !== 1'b1) begin
      fails++;
      $display("FAIL dbz_after: got done=%b busy=%b dbz=%b expected done=0 busy=0 dbz=1",
               bus8.done, bus8.busy, bus8.div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    issue8(1'b0, 8'd3, 8'd5);
    repeat (2) @(negedge clk);
    // Start while busy; a divide by zero would finish at once if wrongly accepted.
    bus8.start = 1'b1;
    bus8.op    = 1'b1;
    bus8.a     = 8'd9;
    bus8.b     = 8'd0;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(lat);
    lat = lat + 3;
    check8("busy_ignore", lat, 9);
    issue8(1'b0, 8'd2, 8'd2);
    tests++;
    if (bus8.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_busy: got %b expected 1", bus8.busy);
    end
    wait_done8(lat);
    check8("back_to_back", lat, 9);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    @(negedge clk);
    issue8(1'b0, 8'hAB, 8'hCD);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb8.pop_back());
    tests++;
    if ({bus8.busy, bus8.done, bus8.div_by_zero, bus8.result_hi, bus8.result_lo} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected zeros",
               bus8.busy, bus8.done, bus8.result_hi, bus8.result_lo);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
    end
    // Start coinciding with reset must be dropped.
    bus8.start = 1'b1;
    bus8.op    = 1'b0;
    bus8.a     = 8'd7;
    bus8.b     = 8'd7;
    reset      = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    reset      = 1'b0;
    tests++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_wins: got busy=%b done=%b expected 0 0", bus8.busy, bus8.done);
    end
    issue8(1'b1, 8'd77, 8'd5);
    wait_done8(lat);
    check8("after_reset", lat, 9);
  endtask

  task automatic test_random8();
    int          lat;
    logic        op;
    logic [7:0]  a;
    logic [7:0]  b;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op = 1'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      issue8(op, a, b);
      wait_done8(lat);
      check8("rand8", lat, (op && b == 8'h00) ? 1 : 9);
    end
  endtask

  task automatic test_random16();
    int          lat;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op = 1'($urandom);
      a  = 16'($urandom);
      b  = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 12));
      issue16(op, a, b);
      wait_done16(lat);
      tests++;
      if (lat !== ((op && b == 16'h0) ? 1 : 17)) begin
        fails++;
        $display("FAIL rand16_latency: got %0d for op=%b b=%h", lat, op, b);
      end
      e = sb16.pop_front();
      tests++;
      if (bus16.result_hi !== e.hi || bus16.result_lo !== e.lo ||
          bus16.div_by_zero !== e.dbz) begin
        fails++;
        $display("FAIL rand16_result: op=%b a=%h b=%h got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                 op, a, b, bus16.result_hi, bus16.result_lo, bus16.div_by_zero,
                 e.hi, e.lo, e.dbz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random8();
    test_random16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
